// File: rtl/stack_controller.sv
// stack_controller: push/pop/peek command FSM driving an external stack memory.
module stack_controller #(
  parameter int REG_BITS = 32,
  parameter int DEPTH    = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd_op,
  input  logic [REG_BITS-1:0] cmd_data,
  output logic                cmd_ready,
  output logic                resp_valid,
  output logic [REG_BITS-1:0] resp_data,
  output logic                resp_err,
  output logic [REG_BITS-1:0] SP,
  output logic [1:0]          StackWriteSrc,
  output logic [REG_BITS-1:0] write_data,
  input  logic [REG_BITS-1:0] read2,
  output logic                full,
  output logic                empty
);
  typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, RESP} state_t;
  state_t              state_q;
  logic [REG_BITS-1:0] sp_q, wdata_q, rdata_q;
  logic [1:0]          wsrc_q;
  logic                rvalid_q, rerr_q, pop_q, err_q;
  assign full          = sp_q == REG_BITS'(DEPTH);
  assign empty         = sp_q == '0;
  assign cmd_ready     = state_q == IDLE;
  assign resp_valid    = rvalid_q;
  assign resp_data     = rdata_q;
  assign resp_err      = rerr_q;
  assign SP            = sp_q;
  assign StackWriteSrc = wsrc_q;
  assign write_data    = wdata_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sp_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wsrc_q   <= 2'b00;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      pop_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: if (cmd_valid) begin
          pop_q <= cmd_op == 2'b01;
          err_q <= 1'b0;
          if (cmd_op == 2'b00 && !full) begin
            wdata_q <= cmd_data;
            wsrc_q  <= 2'b01;
            state_q <= WRITE;
          end else if ((cmd_op == 2'b01 || cmd_op == 2'b10) && !empty) begin
            state_q <= RD_WAIT;
          end else begin
            // rejected commands still travel through RESP to keep a 2-cycle latency
            err_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        WRITE: begin
          wsrc_q   <= 2'b00;
          sp_q     <= sp_q + REG_BITS'(1);
          rvalid_q <= 1'b1;
          rerr_q   <= 1'b0;
          state_q  <= IDLE;
        end
        RD_WAIT: state_q <= RESP;
        RESP: begin
          rvalid_q <= 1'b1;
          rerr_q   <= err_q;
          if (!err_q) begin
            rdata_q <= read2;
            if (pop_q) sp_q <= sp_q - REG_BITS'(1);
          end
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stack_controller.sv
// tb_stack_controller: directed checks of stack_controller against a small stack memory model.
module tb_stack_controller;
  localparam int D = 8;
  logic        clk = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_data = '0, read2 = '0;
  logic        cmd_ready, resp_valid, resp_err, full, empty;
  logic [31:0] resp_data, SP, write_data;
  logic [1:0]  StackWriteSrc;
  logic [31:0] mem [D];
  int compared = 0, mism = 0, wr_cnt = 0, rv_cnt = 0, lat, w0, r0;
  logic [31:0] wr_sp = '1;

  stack_controller #(.REG_BITS(32), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err), .SP(SP),
    .StackWriteSrc(StackWriteSrc), .write_data(write_data), .read2(read2),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (StackWriteSrc != 2'b00) begin
      wr_cnt++;
      wr_sp = SP;
      mem[3'(SP)] = write_data;
    end
    read2 <= mem[3'(SP - 32'd1)];
  end

  always @(negedge clk) if (resp_valid) rv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] d, output int l);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = 32'hBAD0BAD0;
    l = 1;
    while (!resp_valid && l < 10) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sp", SP, 0);
    chk("rst_empty", {31'b0, empty}, 1);
    chk("rst_full", {31'b0, full}, 0);
    chk("rst_wsrc", {30'b0, StackWriteSrc}, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_rdata", resp_data, 0);
    chk("rst_rv_err", {30'b0, resp_valid, resp_err}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'b0, cmd_ready}, 1);

    do_cmd(2'b00, 32'hDEADBEEF, lat);
    chk("push_lat", lat, 2);
    chk("push_err", {31'b0, resp_err}, 0);
    chk("push_sp", SP, 1);
    chk("push_wcnt", wr_cnt, 1);
    chk("push_wsp", wr_sp, 0);
    chk("push_mem", mem[0], 32'hDEADBEEF);
    do_cmd(2'b01, 0, lat);
    chk("pop0_data", resp_data, 32'hDEADBEEF);
    chk("pop0_sp", SP, 0);

    do_cmd(2'b00, 32'h11, lat);
    do_cmd(2'b00, 32'h22, lat);
    chk("push2_sp", SP, 2);
    do_cmd(2'b01, 0, lat);
    chk("pop1_lat", lat, 3);
    chk("pop1_data", resp_data, 32'h22);
    chk("pop1_err", {31'b0, resp_err}, 0);
    chk("pop1_sp", SP, 1);
    do_cmd(2'b01, 0, lat);
    chk("pop2_data", resp_data, 32'h11);
    chk("pop2_sp", SP, 0);
    chk("pop2_empty", {31'b0, empty}, 1);

    do_cmd(2'b00, 32'h5A, lat);
    do_cmd(2'b10, 0, lat);
    chk("peek_lat", lat, 3);
    chk("peek_data", resp_data, 32'h5A);
    chk("peek_sp", SP, 1);
    do_cmd(2'b01, 0, lat);
    chk("peek_pop_sp", SP, 0);

    w0 = wr_cnt;
    do_cmd(2'b01, 0, lat);
    chk("under_lat", lat, 2);
    chk("under_err", {31'b0, resp_err}, 1);
    chk("under_sp", SP, 0);
    chk("under_data", resp_data, 32'h5A);
    do_cmd(2'b10, 0, lat);
    chk("under_peek_err", {31'b0, resp_err}, 1);
    do_cmd(2'b11, 32'h1234, lat);
    chk("rsv_err", {31'b0, resp_err}, 1);
    chk("rsv_lat", lat, 2);
    chk("err_nowrite", wr_cnt, w0);

    for (int i = 0; i < D; i++) do_cmd(2'b00, 32'h100 + i, lat);
    chk("fill_sp", SP, D);
    chk("fill_full", {31'b0, full}, 1);
    do_cmd(2'b10, 0, lat);
    chk("full_peek", resp_data, 32'h107);
    w0 = wr_cnt;
    do_cmd(2'b00, 32'h999, lat);
    chk("over_err", {31'b0, resp_err}, 1);
    chk("over_lat", lat, 2);
    chk("over_sp", SP, D);
    chk("over_nowrite", wr_cnt, w0);
    chk("over_top", mem[D-1], 32'h107);
    chk("over_rdata", resp_data, 32'h107);
    do_cmd(2'b10, 0, lat);
    chk("over_peek", resp_data, 32'h107);

    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01;
    @(negedge clk);
    cmd_valid = 1'b0;
    r0 = rv_cnt;
    #2 reset_n = 1'b0;
    #1;
    chk("rdw_rst_sp", SP, 0);
    chk("rdw_rst_empty", {31'b0, empty}, 1);
    chk("rdw_rst_rv", {31'b0, resp_valid}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rdw_no_resp", rv_cnt, r0);
    chk("rdw_ready", {31'b0, cmd_ready}, 1);
    chk("rdw_sp", SP, 0);

    do_cmd(2'b00, 32'hA5, lat);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 32'hC3;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("wr_state_wsrc", {30'b0, StackWriteSrc}, 1);
    reset_n = 1'b0;
    #1;
    chk("wr_rst_sp", SP, 0);
    chk("wr_rst_wsrc", {30'b0, StackWriteSrc}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("wr_rst_ready", {31'b0, cmd_ready}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
